// File: rtl/earout_pkg.sv
// Shared definitions for the EAR-out pulse generator and the EAR-in tester:
// FSM state encoding, spinner character table and the code reset value.
package earout_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_HIGH = S_HIGH,
        ST_LOW  = S_LOW
    } state_t;

    // Spinner characters, element 0 first: dash (2D), grave accent (60), bar (7C), slash (2F)
    localparam logic [3:0][7:0] SPINNER_TABLE = {8'h2F, 8'h7C, 8'h60, 8'h2D};

    localparam logic [7:0] CODE_RESET = 8'h20;

    function automatic logic [7:0] spinner_char(input logic [1:0] idx);
        return SPINNER_TABLE[idx];
    endfunction

endpackage

// File: rtl/sync_fall_edge.sv
// Two-flop synchronizer for an asynchronous level that idles high, followed by
// a falling-edge detector producing a one-clk pulse.
module sync_fall_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_fall
);

    logic       r_meta;
    logic [1:0] r_edge;   // [0] is the second synchronizer flop, [1] its previous value
    logic       r_live;   // r_meta holds a genuine sample (first clk after reset done)
    logic       r_armed;  // a genuine high has entered r_edge, so a 1->0 pattern is real

    // Synchronize the input and track the last two synchronized samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_edge <= 2'b11;
        end else begin
            r_meta <= i_async;
            r_edge <= {r_edge[0], r_meta};
        end
    end

    // Arm only after a real high sample, so a line held low across reset
    // release is not mistaken for a falling edge of the forced idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_live  <= 1'b1;
            r_armed <= r_armed | (r_live & r_meta);
        end
    end

    assign o_fall = r_armed && (r_edge == 2'b10);

endmodule

// File: rtl/earout_pulsegen.sv
// EAR/MIC output test generator: one burst of PULSES square pulses per frame,
// started by the vsync falling edge, with a spinner code advanced per burst
// and a sticky overrun flag for edges that arrive while a burst is running.
module earout_pulsegen
    import earout_pkg::*;
#(
    parameter int unsigned HALF_CYCLES = 1750,
    parameter int unsigned PULSES      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       vs,
    output logic       ear_out,
    output logic       busy,
    output logic       overrun,
    output logic [7:0] code
);

    localparam logic [15:0] HALF_RELOAD  = 16'(HALF_CYCLES - 1);
    localparam logic [3:0]  PULSE_RELOAD = 4'(PULSES - 1);

    logic        w_frame_start;

    state_t      r_state,     w_state_next;
    logic [15:0] r_half_cnt,  w_half_cnt_next;
    logic [3:0]  r_pulse_cnt, w_pulse_cnt_next;
    logic [1:0]  r_idx,       w_idx_next;
    logic        r_ear,       w_ear_next;
    logic        r_busy,      w_busy_next;
    logic        r_overrun,   w_overrun_next;
    logic [7:0]  r_code,      w_code_next;

    sync_fall_edge u_vs_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (vs),
        .o_fall  (w_frame_start)
    );

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_half_cnt  <= '0;
            r_pulse_cnt <= '0;
            r_idx       <= '0;
            r_ear       <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_code      <= CODE_RESET;
        end else begin
            r_state     <= w_state_next;
            r_half_cnt  <= w_half_cnt_next;
            r_pulse_cnt <= w_pulse_cnt_next;
            r_idx       <= w_idx_next;
            r_ear       <= w_ear_next;
            r_busy      <= w_busy_next;
            r_overrun   <= w_overrun_next;
            r_code      <= w_code_next;
        end
    end

    // Next-state logic: enable low aborts and clears overrun; otherwise run the
    // IDLE/HIGH/LOW burst sequence. An edge seen outside IDLE (including the
    // completion clk itself) only sets overrun.
    always_comb begin
        w_state_next     = r_state;
        w_half_cnt_next  = r_half_cnt;
        w_pulse_cnt_next = r_pulse_cnt;
        w_idx_next       = r_idx;
        w_ear_next       = r_ear;
        w_overrun_next   = r_overrun;
        w_code_next      = r_code;

        if (!enable) begin
            w_state_next   = ST_IDLE;
            w_ear_next     = 1'b0;
            w_overrun_next = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_frame_start) begin
                        w_pulse_cnt_next = PULSE_RELOAD;
                        w_half_cnt_next  = HALF_RELOAD;
                        w_ear_next       = 1'b1;
                        w_state_next     = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (r_half_cnt == '0) begin
                        w_ear_next      = 1'b0;
                        w_half_cnt_next = HALF_RELOAD;
                        w_state_next    = ST_LOW;
                    end else begin
                        w_half_cnt_next = r_half_cnt - 16'd1;
                    end
                    if (w_frame_start) w_overrun_next = 1'b1;
                end
                ST_LOW: begin
                    if (r_half_cnt == '0) begin
                        if (r_pulse_cnt != '0) begin
                            w_pulse_cnt_next = r_pulse_cnt - 4'd1;
                            w_half_cnt_next  = HALF_RELOAD;
                            w_ear_next       = 1'b1;
                            w_state_next     = ST_HIGH;
                        end else begin
                            w_state_next = ST_IDLE;
                            w_code_next  = spinner_char(r_idx);
                            w_idx_next   = r_idx + 2'd1;
                        end
                    end else begin
                        w_half_cnt_next = r_half_cnt - 16'd1;
                    end
                    if (w_frame_start) w_overrun_next = 1'b1;
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_ear_next   = 1'b0;
                end
            endcase
        end

        w_busy_next = (w_state_next != ST_IDLE);
    end

    assign ear_out = r_ear;
    assign busy    = r_busy;
    assign overrun = r_overrun;
    assign code    = r_code;

endmodule

// File: tb/tb_earout_pulsegen.sv
// Directed bench for earout_pulsegen: two instances (HALF=4/PULSES=1 and
// HALF=2/PULSES=3) share clk, reset and vs; each has its own enable.
// Expected per-clk outputs are pushed to a queue and compared as they occur.
module tb_earout_pulsegen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vs = 1'b1;
    logic       en_a = 1'b0;
    logic       en_b = 1'b0;
    logic       ear_a, busy_a, ovr_a;
    logic [7:0] code_a;
    logic       ear_b, busy_b, ovr_b;
    logic [7:0] code_b;

    localparam logic [7:0] C_SP  = 8'h20;
    localparam logic [7:0] C_DSH = 8'h2D;
    localparam logic [7:0] C_BTK = 8'h60;
    localparam logic [7:0] C_BAR = 8'h7C;
    localparam logic [7:0] C_SLS = 8'h2F;

    typedef struct packed {
        logic       ear;
        logic       busy;
        logic [7:0] code;
        logic       ov;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   step     = 0;

    earout_pulsegen #(.HALF_CYCLES(4), .PULSES(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .vs(vs),
        .ear_out(ear_a), .busy(busy_a), .overrun(ovr_a), .code(code_a)
    );

    earout_pulsegen #(.HALF_CYCLES(2), .PULSES(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .vs(vs),
        .ear_out(ear_b), .busy(busy_b), .overrun(ovr_b), .code(code_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s step %0d: observed %h expected %h", tag, step, obs, expv);
    endtask

    task automatic push(input logic e, input logic b, input logic [7:0] c, input logic o);
        exp_t x;
        x.ear = e; x.busy = b; x.code = c; x.ov = o;
        exp_q.push_back(x);
    endtask

    task automatic expect_idle(input int n, input logic [7:0] c, input logic o);
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, c, o);
    endtask

    // Expected trace for clks 1..3+2*h*p after a vs fall: two idle clks of
    // synchronizer latency, then h high / h low per pulse, then the new code.
    task automatic expect_frame(input int h, input int p, input logic [7:0] c0,
                                input logic [7:0] c1, input int ov_from);
        logic o;
        for (int t = 1; t <= 3 + 2*h*p; t++) begin
            o = (ov_from != 0) && (t >= ov_from);
            if (t < 3)                push(1'b0, 1'b0, c0, o);
            else if (t < 3 + 2*h*p)   push((((t - 3) / h) % 2) == 0, 1'b1, c0, o);
            else                      push(1'b0, 1'b0, c1, o);
        end
    endtask

    task automatic drain(input int sel, input int n);
        exp_t x;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            step++;
            n_checks++;
            assert (exp_q.size() != 0) n_pass++;
            else $error("FAIL queue step %0d: observed empty expected entry", step);
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                if (sel == 0) begin
                    check("a_ear",  {7'd0, ear_a},  {7'd0, x.ear});
                    check("a_busy", {7'd0, busy_a}, {7'd0, x.busy});
                    check("a_code", code_a,         x.code);
                    check("a_ovr",  {7'd0, ovr_a},  {7'd0, x.ov});
                end else begin
                    check("b_ear",  {7'd0, ear_b},  {7'd0, x.ear});
                    check("b_busy", {7'd0, busy_b}, {7'd0, x.busy});
                    check("b_code", code_b,         x.code);
                    check("b_ovr",  {7'd0, ovr_b},  {7'd0, x.ov});
                end
            end
        end
    endtask

    task automatic drain_all(input int sel);
        drain(sel, exp_q.size());
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_ear"},  {7'd0, ear_a},  8'd0);
        check({tag, "_a_busy"}, {7'd0, busy_a}, 8'd0);
        check({tag, "_a_ovr"},  {7'd0, ovr_a},  8'd0);
        check({tag, "_a_code"}, code_a,         C_SP);
        check({tag, "_b_ear"},  {7'd0, ear_b},  8'd0);
        check({tag, "_b_busy"}, {7'd0, busy_b}, 8'd0);
        check({tag, "_b_ovr"},  {7'd0, ovr_b},  8'd0);
        check({tag, "_b_code"}, code_b,         C_SP);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        en_a  = 1'b1;
        expect_idle(3, C_SP, 1'b0);
        drain_all(0);

        // Single pulse burst, then the five-frame spinner sequence with wrap
        vs = 1'b0;
        expect_frame(4, 1, C_SP, C_DSH, 0);
        drain_all(0);
        vs = 1'b1;
        expect_idle(4, C_DSH, 1'b0);
        drain_all(0);
        vs = 1'b0; expect_frame(4, 1, C_DSH, C_BTK, 0); drain_all(0);
        vs = 1'b1; expect_idle(4, C_BTK, 1'b0); drain_all(0);
        vs = 1'b0; expect_frame(4, 1, C_BTK, C_BAR, 0); drain_all(0);
        vs = 1'b1; expect_idle(4, C_BAR, 1'b0); drain_all(0);
        vs = 1'b0; expect_frame(4, 1, C_BAR, C_SLS, 0); drain_all(0);
        vs = 1'b1; expect_idle(4, C_SLS, 1'b0); drain_all(0);
        vs = 1'b0; expect_frame(4, 1, C_SLS, C_DSH, 0); drain_all(0);
        vs = 1'b1; expect_idle(4, C_DSH, 1'b0); drain_all(0);

        // Second fall mid-burst: burst unchanged, overrun sticky until enable low
        vs = 1'b0;
        expect_frame(4, 1, C_DSH, C_BTK, 8);
        drain(0, 3);
        vs = 1'b1;
        drain(0, 2);
        vs = 1'b0;
        drain_all(0);
        vs = 1'b1;
        expect_idle(4, C_BTK, 1'b1);
        drain_all(0);
        en_a = 1'b0;
        expect_idle(3, C_BTK, 1'b0);
        drain_all(0);

        // Edge arriving on the completion clk: no new burst, overrun set
        en_a = 1'b1;
        expect_idle(3, C_BTK, 1'b0);
        drain_all(0);
        vs = 1'b0;
        expect_frame(4, 1, C_BTK, C_BAR, 11);
        drain(0, 3);
        vs = 1'b1;
        drain(0, 5);
        vs = 1'b0;
        drain_all(0);
        expect_idle(4, C_BAR, 1'b1);
        drain_all(0);
        vs = 1'b1;
        en_a = 1'b0;
        expect_idle(3, C_BAR, 1'b0);
        drain_all(0);

        // Enable dropped 3 clk into HIGH: abort next clk, code unchanged
        en_a = 1'b1;
        expect_idle(3, C_BAR, 1'b0);
        drain_all(0);
        vs = 1'b0;
        expect_idle(2, C_BAR, 1'b0);
        for (int i = 0; i < 3; i++) push(1'b1, 1'b1, C_BAR, 1'b0);
        drain_all(0);
        en_a = 1'b0;
        expect_idle(4, C_BAR, 1'b0);
        drain_all(0);
        vs = 1'b1;
        expect_idle(4, C_BAR, 1'b0);
        drain_all(0);

        // Three-pulse burst on the second instance
        en_b = 1'b1;
        expect_idle(3, C_SP, 1'b0);
        drain_all(1);
        vs = 1'b0;
        expect_frame(2, 3, C_SP, C_DSH, 0);
        drain_all(1);
        vs = 1'b1;
        expect_idle(4, C_DSH, 1'b0);
        drain_all(1);

        // Reset mid-LOW with vs held low across release
        vs = 1'b0;
        expect_idle(2, C_DSH, 1'b0);
        push(1'b1, 1'b1, C_DSH, 1'b0);
        push(1'b1, 1'b1, C_DSH, 1'b0);
        push(1'b0, 1'b1, C_DSH, 1'b0);
        drain_all(1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_idle(6, C_SP, 1'b0);
        drain_all(1);
        vs = 1'b1;
        expect_idle(4, C_SP, 1'b0);
        drain_all(1);
        vs = 1'b0;
        expect_frame(2, 3, C_SP, C_DSH, 0);
        drain_all(1);
        vs = 1'b1;
        expect_idle(2, C_DSH, 1'b0);
        drain_all(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
